// File: rtl/acc_bank.sv
//=============================================================================
// acc_bank : ping-pong 16x16 partial-sum accumulator that streams tiles to the ppu
// Optional saturation: ACC_BANK_SAT_EN.  Rev 1.0
//=============================================================================
`default_nettype none

module acc_bank #(
   parameter int LANES  = 16,
   parameter int ROWS   = 16,
   parameter int PSUM_W = 20,
   parameter int ACC_W  = 24
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_psum_valid,
   output logic                    o_psum_ready,
   input  logic [LANES*PSUM_W-1:0] i_psum_data,
   input  logic                    i_psum_first,
   input  logic                    i_psum_last,
   output logic                    o_ppu_start,
   output logic                    o_acc_valid,
   output logic [LANES*ACC_W-1:0]  o_acc_data,
   output logic                    o_busy
);

   localparam int            RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   typedef enum logic [1:0] {
      D_IDLE   = 2'd0,
      D_START  = 2'd1,
      D_STREAM = 2'd2
   } drain_e;

   logic [ACC_W-1:0] bank_q [2][ROWS][LANES];
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [RW-1:0]    wr_row_q, wr_row_d;
   logic [RW-1:0]    rd_row_q, rd_row_d;
   logic [1:0]       full_q, full_d;
   drain_e           state_q, state_d;
   logic             beat, tile_done, drain_done;

   // Per-lane overwrite or accumulate of a sign-extended partial sum.
   function automatic logic [ACC_W-1:0] lane_next(input logic [ACC_W-1:0]  acc,
                                                  input logic [PSUM_W-1:0] psum,
                                                  input logic              first);
`ifdef ACC_BANK_SAT_EN
      logic [ACC_W:0] ext, base, sum;
      ext  = {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum};
      base = first ? '0 : {acc[ACC_W-1], acc};
      sum  = base + ext;
      if (sum[ACC_W] != sum[ACC_W-1])
         return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return sum[ACC_W-1:0];
`else
      logic [ACC_W-1:0] ext, base;
      ext  = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
      base = first ? '0 : acc;
      return base + ext;
`endif
   endfunction

   assign o_psum_ready = !full_q[wr_bank_q];
   assign beat         = i_psum_valid && o_psum_ready;
   assign tile_done    = beat && i_psum_last && (wr_row_q == LAST_ROW);
   assign drain_done   = (state_q == D_STREAM) && (rd_row_q == LAST_ROW);
   assign o_busy       = (full_q != 2'b00) || (state_q != D_IDLE);

   // Set and clear always target different banks, so both may land on one edge.
   always_comb begin
      wr_row_d  = wr_row_q;
      wr_bank_d = wr_bank_q;
      full_d    = full_q;
      if (beat)
         wr_row_d = (wr_row_q == LAST_ROW) ? '0 : wr_row_q + 1'b1;
      if (tile_done) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = !wr_bank_q;
      end
      if (drain_done)
         full_d[rd_bank_q] = 1'b0;
   end

   always_comb begin
      state_d     = state_q;
      rd_row_d    = rd_row_q;
      rd_bank_d   = rd_bank_q;
      o_ppu_start = 1'b0;
      o_acc_valid = 1'b0;
      case (state_q)
         D_IDLE: begin
            if (full_q[rd_bank_q])
               state_d = D_START;
         end
         D_START: begin
            o_ppu_start = 1'b1;
            rd_row_d    = '0;
            state_d     = D_STREAM;
         end
         D_STREAM: begin
            o_acc_valid = 1'b1;
            rd_row_d    = rd_row_q + 1'b1;
            if (drain_done) begin
               rd_row_d  = '0;
               rd_bank_d = !rd_bank_q;
               state_d   = D_IDLE;
            end
         end
         default: state_d = D_IDLE;
      endcase
   end

   always_comb begin
      o_acc_data = '0;
      if (state_q == D_STREAM)
         for (int k = 0; k < LANES; k++)
            o_acc_data[k*ACC_W +: ACC_W] = bank_q[rd_bank_q][rd_row_q][k];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_row_q  <= '0;
         rd_row_q  <= '0;
         full_q    <= 2'b00;
         state_q   <= D_IDLE;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_row_q  <= wr_row_d;
         rd_row_q  <= rd_row_d;
         full_q    <= full_d;
         state_q   <= state_d;
      end
   end

   // Bank storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (beat)
         for (int k = 0; k < LANES; k++)
            bank_q[wr_bank_q][wr_row_q][k] <=
               lane_next(bank_q[wr_bank_q][wr_row_q][k],
                         i_psum_data[k*PSUM_W +: PSUM_W], i_psum_first);
   end

endmodule

`default_nettype wire

// File: tb/tb_acc_bank.sv
//=============================================================================
// tb_acc_bank : randomized bench for acc_bank against a tile-level arithmetic model
// Honours ACC_BANK_SAT_EN for expected overflow behaviour.  Rev 1.0
//=============================================================================
`default_nettype none

module tb_acc_bank;

   localparam int LANES  = 16;
   localparam int ROWS   = 16;
   localparam int PSUM_W = 20;
   localparam int ACC_W  = 24;

`ifdef ACC_BANK_SAT_EN
   localparam longint           AMAX    = (longint'(1) << (ACC_W-1)) - 1;
   localparam longint           AMIN    = -(longint'(1) << (ACC_W-1));
   localparam logic [ACC_W-1:0] EXP_POS = 24'h7FFFFF;
   localparam logic [ACC_W-1:0] EXP_NEG = 24'h800000;
`else
   localparam logic [ACC_W-1:0] EXP_POS = 24'h9FFFEC;
   localparam logic [ACC_W-1:0] EXP_NEG = 24'h600000;
`endif

   typedef logic [LANES*ACC_W-1:0]  row_t;
   typedef logic [LANES*PSUM_W-1:0] psum_t;

   logic  clk = 1'b0;
   logic  i_rst = 1'b1;
   logic  i_psum_valid = 1'b0;
   logic  o_psum_ready;
   psum_t i_psum_data = '0;
   logic  i_psum_first = 1'b0;
   logic  i_psum_last = 1'b0;
   logic  o_ppu_start;
   logic  o_acc_valid;
   row_t  o_acc_data;
   logic  o_busy;

   acc_bank dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_psum_valid (i_psum_valid),
      .o_psum_ready (o_psum_ready),
      .i_psum_data  (i_psum_data),
      .i_psum_first (i_psum_first),
      .i_psum_last  (i_psum_last),
      .o_ppu_start  (o_ppu_start),
      .o_acc_valid  (o_acc_valid),
      .o_acc_data   (o_acc_data),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   // Stream log, sampled on the falling edge.
   row_t got_q[$];
   row_t exp_q[$];
   int   vcyc_q[$];
   int   start_q[$];
   int   zviol = 0;

   always @(negedge clk) begin
      if (o_ppu_start) start_q.push_back(cyc);
      if (o_acc_valid) begin
         got_q.push_back(o_acc_data);
         vcyc_q.push_back(cyc);
      end else if (o_acc_data !== '0) begin
         zviol++;
      end
   end

   // Tile-level model: plain integer sums folded to the accumulator range.
   longint mbank [2][ROWS][LANES];
   int     mwr_bank = 0;
   int     mwr_row  = 0;

   function automatic longint fold(input longint v);
`ifdef ACC_BANK_SAT_EN
      if (v > AMAX) return AMAX;
      if (v < AMIN) return AMIN;
      return v;
`else
      logic signed [ACC_W-1:0] t;
      t = v[ACC_W-1:0];
      return longint'(t);
`endif
   endfunction

   task automatic model_beat(input psum_t d, input logic first, input logic last);
      longint p;
      longint v;
      row_t   r;
      for (int k = 0; k < LANES; k++) begin
         p = longint'($signed(d[k*PSUM_W +: PSUM_W]));
         mbank[mwr_bank][mwr_row][k] = fold(first ? p : mbank[mwr_bank][mwr_row][k] + p);
      end
      if (last && mwr_row == ROWS-1) begin
         for (int rr = 0; rr < ROWS; rr++) begin
            for (int k = 0; k < LANES; k++) begin
               v = mbank[mwr_bank][rr][k];
               r[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
            end
            exp_q.push_back(r);
         end
         mwr_bank = 1 - mwr_bank;
      end
      mwr_row = (mwr_row + 1) % ROWS;
   endtask

   function automatic psum_t rand_row();
      psum_t d;
      for (int k = 0; k < LANES; k++) d[k*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
      return d;
   endfunction

   function automatic logic [ACC_W-1:0] lane(input row_t r, input int k);
      return r[k*ACC_W +: ACC_W];
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      got_q.delete();
      exp_q.delete();
      vcyc_q.delete();
      start_q.delete();
   endtask

   task automatic send(input psum_t d, input logic first, input logic last);
      int guard = 0;
      i_psum_valid = 1'b1;
      i_psum_data  = d;
      i_psum_first = first;
      i_psum_last  = last;
      while (!o_psum_ready && guard < 200) begin
         tick();
         guard++;
      end
      if (!o_psum_ready) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout: ready got 0 want 1 at cycle %0d", cyc);
      end else begin
         model_beat(d, first, last);
      end
      tick();
      i_psum_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((o_busy || got_q.size() < exp_q.size()) && guard < 600) begin
         tick();
         guard++;
      end
      if (guard >= 600) begin
         compared++;
         mismatched++;
         $display("FAIL idle_timeout: busy got %0b want 0, rows got %0d want %0d",
                  o_busy, got_q.size(), exp_q.size());
      end
      repeat (2) tick();
   endtask

   //--------------------------------------------------------------------------
   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) tick();
      compared += 5;
      if (o_psum_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %b want 1", o_psum_ready); end
      if (o_ppu_start !== 1'b0) begin mismatched++; $display("FAIL rst_start got %b want 0", o_ppu_start); end
      if (o_acc_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", o_acc_valid); end
      if (o_acc_data !== '0) begin mismatched++; $display("FAIL rst_data got %h want 0", o_acc_data); end
      if (o_busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %b want 0", o_busy); end
      mwr_bank = 0;
      mwr_row  = 0;
      i_rst    = 1'b0;
      tick();
   endtask

   task automatic test_single_pass();
      psum_t d;
      clear_logs();
      for (int r = 0; r < ROWS; r++) begin
         for (int k = 0; k < LANES; k++) d[k*PSUM_W +: PSUM_W] = PSUM_W'(r*16 + k);
         send(d, 1'b1, 1'b1);
      end
      wait_idle();
      compared += 2;
      if (start_q.size() != 1) begin mismatched++; $display("FAIL t1_starts got %0d want 1", start_q.size()); end
      if (got_q.size() != ROWS) begin mismatched++; $display("FAIL t1_rows got %0d want %0d", got_q.size(), ROWS); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared++;
         if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL t1_row%0d got %h want %h", i, got_q[i], exp_q[i]); end
         if (start_q.size() > 0) begin
            compared++;
            if (vcyc_q[i] != start_q[0] + 1 + i) begin
               mismatched++;
               $display("FAIL t1_time%0d got %0d want %0d", i, vcyc_q[i], start_q[0] + 1 + i);
            end
         end
      end
   endtask

   task automatic test_multipass();
      psum_t d;
      clear_logs();
      for (int p = 0; p < 3; p++)
         for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < LANES; k++) d[k*PSUM_W +: PSUM_W] = PSUM_W'(100);
            if (p == 1) d[PSUM_W-1:0] = PSUM_W'(-50);
            send(d, p == 0, p == 2);
         end
      wait_idle();
      compared++;
      if (got_q.size() != ROWS) begin mismatched++; $display("FAIL t2_rows got %0d want %0d", got_q.size(), ROWS); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared += 3;
         if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL t2_row%0d got %h want %h", i, got_q[i], exp_q[i]); end
         if (lane(got_q[i], 0) !== 24'd150) begin mismatched++; $display("FAIL t2_lane0_r%0d got %0d want 150", i, lane(got_q[i], 0)); end
         if (lane(got_q[i], 9) !== 24'd300) begin mismatched++; $display("FAIL t2_lane9_r%0d got %0d want 300", i, lane(got_q[i], 9)); end
      end
   endtask

   task automatic test_back_to_back();
      int    beats = 0, drop_at = -1, rise_cyc = -1, guard = 0;
      psum_t d;
      clear_logs();
      d = rand_row();
      i_psum_valid = 1'b1;
      i_psum_first = 1'b1;
      i_psum_last  = 1'b1;
      i_psum_data  = d;
      while (beats < 3*ROWS && guard < 600) begin
         if (o_psum_ready) begin
            if (drop_at >= 0 && rise_cyc < 0) rise_cyc = cyc;
            model_beat(d, 1'b1, 1'b1);
            beats++;
            tick();
            d = rand_row();
            i_psum_data = d;
         end else begin
            if (drop_at < 0) drop_at = beats;
            tick();
         end
         guard++;
      end
      i_psum_valid = 1'b0;
      wait_idle();
      compared += 3;
      if (drop_at != 32) begin mismatched++; $display("FAIL t3_drop_beat got %0d want 32", drop_at); end
      if (got_q.size() != 3*ROWS) begin mismatched++; $display("FAIL t3_rows got %0d want %0d", got_q.size(), 3*ROWS); end
      if (start_q.size() != 3) begin
         mismatched++;
         $display("FAIL t3_starts got %0d want 3", start_q.size());
      end else begin
         compared += 2;
         if (start_q[1] - start_q[0] != 18) begin mismatched++; $display("FAIL t3_gap01 got %0d want 18", start_q[1] - start_q[0]); end
         if (start_q[2] - start_q[1] != 18) begin mismatched++; $display("FAIL t3_gap12 got %0d want 18", start_q[2] - start_q[1]); end
      end
      if (got_q.size() > ROWS - 1) begin
         compared++;
         if (rise_cyc != vcyc_q[ROWS-1] + 1) begin
            mismatched++;
            $display("FAIL t3_ready_rise got %0d want %0d", rise_cyc, vcyc_q[ROWS-1] + 1);
         end
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared++;
         if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL t3_row%0d got %h want %h", i, got_q[i], exp_q[i]); end
         if (i / ROWS < start_q.size()) begin
            compared++;
            if (vcyc_q[i] != start_q[i/ROWS] + 1 + i % ROWS) begin
               mismatched++;
               $display("FAIL t3_time%0d got %0d want %0d", i, vcyc_q[i], start_q[i/ROWS] + 1 + i % ROWS);
            end
         end
      end
   endtask

   task automatic test_overflow(input logic [PSUM_W-1:0] v, input logic [ACC_W-1:0] want);
      psum_t d;
      clear_logs();
      d = {LANES{v}};
      for (int p = 0; p < 20; p++)
         for (int r = 0; r < ROWS; r++) send(d, p == 0, p == 19);
      wait_idle();
      compared++;
      if (got_q.size() != ROWS) begin mismatched++; $display("FAIL t4_rows got %0d want %0d", got_q.size(), ROWS); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared += 2;
         if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL t4_row%0d got %h want %h", i, got_q[i], exp_q[i]); end
         if (lane(got_q[i], i) !== want) begin mismatched++; $display("FAIL t4_lane_r%0d got %h want %h", i, lane(got_q[i], i), want); end
      end
   endtask

   task automatic test_reset_mid_drain();
      int guard = 0;
      clear_logs();
      for (int r = 0; r < ROWS; r++) send(rand_row(), 1'b1, 1'b1);
      while (got_q.size() < 6 && guard < 100) begin
         tick();
         guard++;
      end
      i_rst = 1'b1;
      tick();
      compared += 5;
      if (o_acc_valid !== 1'b0) begin mismatched++; $display("FAIL t5_valid got %b want 0", o_acc_valid); end
      if (o_acc_data !== '0) begin mismatched++; $display("FAIL t5_data got %h want 0", o_acc_data); end
      if (o_ppu_start !== 1'b0) begin mismatched++; $display("FAIL t5_start got %b want 0", o_ppu_start); end
      if (o_psum_ready !== 1'b1) begin mismatched++; $display("FAIL t5_ready got %b want 1", o_psum_ready); end
      if (o_busy !== 1'b0) begin mismatched++; $display("FAIL t5_busy got %b want 0", o_busy); end
      i_rst    = 1'b0;
      mwr_bank = 0;
      mwr_row  = 0;
      repeat (30) tick();
      compared += 2;
      if (got_q.size() != 6) begin mismatched++; $display("FAIL t5_rows got %0d want 6", got_q.size()); end
      if (start_q.size() != 1) begin mismatched++; $display("FAIL t5_starts got %0d want 1", start_q.size()); end
   endtask

   task automatic test_same_edge();
      int guard = 0, last_beat = -1;
      clear_logs();
      for (int r = 0; r < ROWS; r++) send(rand_row(), 1'b1, 1'b1);
      while (start_q.size() == 0 && guard < 50) begin
         tick();
         guard++;
      end
      tick();
      for (int r = 0; r < ROWS; r++) begin
         if (r == ROWS-1) last_beat = cyc;
         send(rand_row(), 1'b1, 1'b1);
      end
      compared += 2;
      if (o_psum_ready !== 1'b1) begin mismatched++; $display("FAIL t6_ready got %b want 1", o_psum_ready); end
      if (o_busy !== 1'b1) begin mismatched++; $display("FAIL t6_busy got %b want 1", o_busy); end
      wait_idle();
      compared += 2;
      if (got_q.size() != 2*ROWS) begin mismatched++; $display("FAIL t6_rows got %0d want %0d", got_q.size(), 2*ROWS); end
      if (start_q.size() != 2) begin
         mismatched++;
         $display("FAIL t6_starts got %0d want 2", start_q.size());
      end else if (got_q.size() > ROWS - 1) begin
         compared += 2;
         if (last_beat != vcyc_q[ROWS-1]) begin mismatched++; $display("FAIL t6_align got %0d want %0d", last_beat, vcyc_q[ROWS-1]); end
         if (start_q[1] != vcyc_q[ROWS-1] + 2) begin mismatched++; $display("FAIL t6_start1 got %0d want %0d", start_q[1], vcyc_q[ROWS-1] + 2); end
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared++;
         if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL t6_row%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_multipass();
      test_back_to_back();
      test_overflow(20'h7FFFF, EXP_POS);
      test_overflow(20'h80000, EXP_NEG);
      test_reset_mid_drain();
      test_same_edge();
      compared++;
      if (zviol != 0) begin mismatched++; $display("FAIL idle_data_zero: nonzero samples got %0d want 0", zviol); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation got past 500000 time units");
      $fatal(1);
   end

endmodule

`default_nettype wire
